// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel pixel pipeline: default pixel width, pixel type,
// and the fill-counter width helper.
package sobel_pkg;

  localparam int unsigned PIX_W = 16;

  typedef logic [PIX_W-1:0] pix_t;

  // Bits needed to count 0..depth inclusive; never narrower than one bit.
  function automatic int unsigned clog2_plus1(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pixel_delay_line_if.sv
// Stream/status bundle for pixel_delay_line. The taps bus exists only when
// DELAY_TAPS_EN is defined.
interface pixel_delay_line_if
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned DEPTH = 2
);
  localparam int unsigned CNT_W = clog2_plus1(DEPTH);

  logic             clear;
  logic             in_valid;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             primed;
  logic [CNT_W-1:0] fill;
`ifdef DELAY_TAPS_EN
  logic [WIDTH*DEPTH-1:0] taps;

  modport master (output clear, in_valid, data_in,
                  input  data_out, out_valid, primed, fill, taps);
  modport slave  (input  clear, in_valid, data_in,
                  output data_out, out_valid, primed, fill, taps);
`else
  modport master (output clear, in_valid, data_in,
                  input  data_out, out_valid, primed, fill);
  modport slave  (input  clear, in_valid, data_in,
                  output data_out, out_valid, primed, fill);
`endif

endinterface

// File: rtl/delay_fill_ctr.sv
// Saturating fill counter for the delay line, with registered primed level and
// registered out_valid strobe.
module delay_fill_ctr
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNT_W = clog2_plus1(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  output logic [CNT_W-1:0] o_fill,
  output logic             o_primed,
  output logic             o_out_valid
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] r_fill;
  logic [CNT_W-1:0] w_fill_d;
  logic             r_primed;
  logic             r_out_valid;
  logic             w_out_valid_d;

  always_comb begin
    w_fill_d      = r_fill;
    w_out_valid_d = 1'b0;
    if (i_clear) begin
      w_fill_d = '0;
    end else if (i_valid) begin
      if (r_fill != FULL) w_fill_d = r_fill + 1'b1;
      // This accept pushes a fully delayed sample into the last stage.
      w_out_valid_d = (r_fill >= LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill      <= '0;
      r_primed    <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_fill      <= w_fill_d;
      r_primed    <= (w_fill_d == FULL);
      r_out_valid <= w_out_valid_d;
    end
  end

  assign o_fill      = r_fill;
  assign o_primed    = r_primed;
  assign o_out_valid = r_out_valid;

endmodule

// File: rtl/pixel_delay_line.sv
// Valid-qualified pixel delay line: each accepted sample emerges DEPTH accepts later.
// Define DELAY_TAPS_EN to export every stage on bus.taps.
module pixel_delay_line
  import sobel_pkg::*;
#(
  parameter int unsigned WIDTH = PIX_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pixel_delay_line_if.slave  bus
);

  localparam int unsigned CNT_W = clog2_plus1(DEPTH);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_d;

    if (i == 0) begin : g_head
      assign w_d = bus.data_in;
    end else begin : g_tail
      assign w_d = g_stage[i-1].r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_q <= '0;
      end else if (bus.clear) begin
        r_q <= '0;
      end else if (bus.in_valid) begin
        r_q <= w_d;
      end
    end

`ifdef DELAY_TAPS_EN
    assign bus.taps[i*WIDTH +: WIDTH] = r_q;
`endif
  end

  assign bus.data_out = g_stage[DEPTH-1].r_q;

  delay_fill_ctr #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fill_ctr (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (bus.clear),
    .i_valid     (bus.in_valid),
    .o_fill      (bus.fill),
    .o_primed    (bus.primed),
    .o_out_valid (bus.out_valid)
  );

endmodule

// File: tb/tb_pixel_delay_line.sv
// Directed bench for pixel_delay_line: DEPTH=2/WIDTH=16 and DEPTH=1/WIDTH=8 instances,
// plus a DEPTH=4 taps instance when DELAY_TAPS_EN is defined.
module tb_pixel_delay_line;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pixel_delay_line_if #(.WIDTH(16), .DEPTH(2)) bus2 ();
  pixel_delay_line_if #(.WIDTH(8),  .DEPTH(1)) bus1 ();

  pixel_delay_line #(.WIDTH(16), .DEPTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  pixel_delay_line #(.WIDTH(8),  .DEPTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

`ifdef DELAY_TAPS_EN
  pixel_delay_line_if #(.WIDTH(16), .DEPTH(4)) bus4 ();
  pixel_delay_line #(.WIDTH(16), .DEPTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
`endif

  // {out_valid, primed, fill[1:0], data_out[15:0]} of the DEPTH=2 instance
  function automatic logic [19:0] obs2();
    return {bus2.out_valid, bus2.primed, bus2.fill, bus2.data_out};
  endfunction

  // {out_valid, primed, fill[0], data_out[7:0]} of the DEPTH=1 instance
  function automatic logic [10:0] obs1();
    return {bus1.out_valid, bus1.primed, bus1.fill, bus1.data_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (obs2() !== 20'h0) begin
      errors++;
      $display("FAIL reset_d2: got %h expected %h", obs2(), 20'h0);
    end
    checks++;
    if (obs1() !== 11'h0) begin
      errors++;
      $display("FAIL reset_d1: got %h expected %h", obs1(), 11'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [19:0] exp;
    for (int k = 1; k <= 5; k++) begin
      bus2.in_valid = 1'b1;
      bus2.data_in  = 16'(k);
      tick();
      exp = {(k >= 2), (k >= 2), 2'((k >= 2) ? 2 : k), 16'((k >= 2) ? k - 1 : 0)};
      checks++;
      if (obs2() !== exp) begin
        errors++;
        $display("FAIL stream_k%0d: got %h expected %h", k, obs2(), exp);
      end
    end
    bus2.in_valid = 1'b0;
    tick();
    checks++;
    if (obs2() !== {1'b0, 1'b1, 2'd2, 16'h0004}) begin
      errors++;
      $display("FAIL stream_idle_hold: got %h expected %h", obs2(), {1'b0, 1'b1, 2'd2, 16'h0004});
    end
  endtask

  task automatic test_gapped();
    logic [15:0] data [6] = '{16'hAAAA, 16'h0, 16'h0, 16'h0, 16'hBBBB, 16'h0};
    logic        vld  [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        eov  [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] edo  [9] = '{16'h0, 16'h0, 16'h0, 16'h0, 16'hAAAA, 16'hAAAA, 16'hAAAA,
                             16'hBBBB, 16'hBBBB};
    int strobes = 0;
    bus2.clear = 1'b1;
    tick();
    bus2.clear = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus2.in_valid = vld[c];
      bus2.data_in  = (c < 6) ? data[c] : 16'hCCCC;
      tick();
      if (bus2.out_valid === 1'b1) strobes++;
      checks++;
      if ({bus2.out_valid, bus2.data_out} !== {eov[c], edo[c]}) begin
        errors++;
        $display("FAIL gapped_c%0d: got %h expected %h", c, {bus2.out_valid, bus2.data_out},
                 {eov[c], edo[c]});
      end
    end
    checks++;
    if (strobes !== 2) begin
      errors++;
      $display("FAIL gapped_strobe_count: got %0d expected 2", strobes);
    end
  endtask

  task automatic test_clear_priority();
    bus2.clear    = 1'b1;
    bus2.in_valid = 1'b1;
    bus2.data_in  = 16'h1234;
    tick();
    bus2.clear = 1'b0;
    checks++;
    if (obs2() !== 20'h0) begin
      errors++;
      $display("FAIL clear_flush: got %h expected %h", obs2(), 20'h0);
    end
    bus2.data_in = 16'h0101;
    tick();
    checks++;
    if (obs2() !== {1'b0, 1'b0, 2'd1, 16'h0000}) begin
      errors++;
      $display("FAIL clear_refill1: got %h expected %h", obs2(), {1'b0, 1'b0, 2'd1, 16'h0000});
    end
    bus2.data_in = 16'h0202;
    tick();
    checks++;
    if (obs2() !== {1'b1, 1'b1, 2'd2, 16'h0101}) begin
      errors++;
      $display("FAIL clear_refill2: got %h expected %h", obs2(), {1'b1, 1'b1, 2'd2, 16'h0101});
    end
    bus2.data_in = 16'h0303;
    tick();
    checks++;
    if (obs2() !== {1'b1, 1'b1, 2'd2, 16'h0202}) begin
      errors++;
      $display("FAIL clear_refill3: got %h expected %h", obs2(), {1'b1, 1'b1, 2'd2, 16'h0202});
    end
    bus2.in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    // Line is full here (0x0303, 0x0202); drop reset away from any clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs2() !== 20'h0) begin
      errors++;
      $display("FAIL async_reset_now: got %h expected %h", obs2(), 20'h0);
    end
    #2;
    rst_n = 1'b1;
    bus2.in_valid = 1'b1;
    bus2.data_in  = 16'h000A;
    tick();
    checks++;
    if (obs2() !== {1'b0, 1'b0, 2'd1, 16'h0000}) begin
      errors++;
      $display("FAIL async_refill1: got %h expected %h", obs2(), {1'b0, 1'b0, 2'd1, 16'h0000});
    end
    bus2.data_in = 16'h000B;
    tick();
    bus2.in_valid = 1'b0;
    checks++;
    if (obs2() !== {1'b1, 1'b1, 2'd2, 16'h000A}) begin
      errors++;
      $display("FAIL async_refill2: got %h expected %h", obs2(), {1'b1, 1'b1, 2'd2, 16'h000A});
    end
  endtask

  task automatic test_depth1();
    bus1.in_valid = 1'b1;
    bus1.data_in  = 8'h5A;
    tick();
    bus1.in_valid = 1'b0;
    checks++;
    if (obs1() !== {1'b1, 1'b1, 1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL d1_accept: got %h expected %h", obs1(), {1'b1, 1'b1, 1'b1, 8'h5A});
    end
    tick();
    checks++;
    if (obs1() !== {1'b0, 1'b1, 1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL d1_idle: got %h expected %h", obs1(), {1'b0, 1'b1, 1'b1, 8'h5A});
    end
    bus1.in_valid = 1'b1;
    bus1.data_in  = 8'hC3;
    tick();
    checks++;
    if (obs1() !== {1'b1, 1'b1, 1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL d1_second: got %h expected %h", obs1(), {1'b1, 1'b1, 1'b1, 8'hC3});
    end
    bus1.clear = 1'b1;
    tick();
    bus1.clear    = 1'b0;
    bus1.in_valid = 1'b0;
    checks++;
    if (obs1() !== 11'h0) begin
      errors++;
      $display("FAIL d1_clear: got %h expected %h", obs1(), 11'h0);
    end
  endtask

`ifdef DELAY_TAPS_EN
  task automatic test_taps();
    logic [15:0] vals [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    for (int k = 0; k < 4; k++) begin
      bus4.in_valid = 1'b1;
      bus4.data_in  = vals[k];
      tick();
    end
    bus4.in_valid = 1'b0;
    checks++;
    if (bus4.taps !== 64'h0011_0022_0033_0044) begin
      errors++;
      $display("FAIL taps_window: got %h expected %h", bus4.taps, 64'h0011_0022_0033_0044);
    end
    checks++;
    if ({bus4.out_valid, bus4.primed, bus4.fill, bus4.data_out} !==
        {1'b1, 1'b1, 3'd4, 16'h0011}) begin
      errors++;
      $display("FAIL taps_dout: got %h expected %h",
               {bus4.out_valid, bus4.primed, bus4.fill, bus4.data_out},
               {1'b1, 1'b1, 3'd4, 16'h0011});
    end
    bus4.clear = 1'b1;
    tick();
    bus4.clear = 1'b0;
    checks++;
    if (bus4.taps !== 64'h0) begin
      errors++;
      $display("FAIL taps_clear: got %h expected %h", bus4.taps, 64'h0);
    end
  endtask
`endif

  initial begin
    bus2.clear = 1'b0; bus2.in_valid = 1'b0; bus2.data_in = '0;
    bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.data_in = '0;
`ifdef DELAY_TAPS_EN
    bus4.clear = 1'b0; bus4.in_valid = 1'b0; bus4.data_in = '0;
`endif
    test_reset();
    test_stream();
    test_gapped();
    test_clear_priority();
    test_async_reset();
    test_depth1();
`ifdef DELAY_TAPS_EN
    test_taps();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
